// File: rtl/eq_pkg.sv
// Shared types and helpers for the equivalence-check step controller.
package eq_pkg;

  localparam int EQ_MAX_DUT = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } eq_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/eq_drain_cnt.sv
// Per-DUT drain window: counts cycles of held completion, stalls once the window is used up.
module eq_drain_cnt
  import eq_pkg::*;
#(
  parameter int DRAIN = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_complete,
  output logic o_stall
);

  localparam int WAIT_W = $clog2(DRAIN + 2);
  localparam logic [WAIT_W-1:0] DRAIN_V = WAIT_W'(DRAIN);

  logic [WAIT_W-1:0] r_wait;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) r_wait <= '0;
    else if (i_en) begin
      // A dropped completion restarts the window from zero
      if (i_complete) r_wait <= WAIT_W'(sat_inc(32'(r_wait), 32'(DRAIN)));
      else            r_wait <= '0;
    end
  end

  assign o_stall = i_complete & (r_wait >= DRAIN_V);

endmodule

// File: rtl/eq_step_ctrl.sv
// Step/termination controller: gates N DUTs via clock-enables, then compares their outputs to DUT 0.
module eq_step_ctrl
  import eq_pkg::*;
#(
  parameter int N_DUT   = 2,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16,
  parameter int DRAIN   = 6,
  parameter int TIMEOUT = 1000
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      start,
  input  logic [N_DUT-1:0]          dut_complete,
  input  logic [N_DUT-1:0]          dut_valid,
  input  logic [N_DUT*DATA_W-1:0]   dut_data,
  output logic [N_DUT-1:0]          dut_step,
  output logic [2:0]                phase,
  output logic [CNT_W-1:0]          cycle_cnt,
  output logic                      done,
  output logic                      match,
  output logic                      timeout,
  output logic [N_DUT-1:0]          mismatch_mask
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  eq_state_t         r_state, w_next;
  logic              w_run, w_start_ok, w_to;
  logic [N_DUT-1:0]  w_stall, w_diff;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done, r_match, r_timeout;
  logic [N_DUT-1:0]  r_mask;

  assign w_run      = (r_state == ST_RUN);
  assign w_start_ok = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign dut_step   = {N_DUT{w_run}} & ~w_stall;

  genvar g;
  generate
    for (g = 0; g < N_DUT; g++) begin : g_dut
      eq_drain_cnt #(.DRAIN(DRAIN)) u_drain (
        .clk        (ap_clk),
        .rst_n      (ap_rst_n),
        .i_clr      (w_start_ok),
        .i_en       (w_run),
        .i_complete (dut_complete[g]),
        .o_stall    (w_stall[g])
      );
      if (g == 0) begin : g_ref
        assign w_diff[g] = 1'b0;
      end else begin : g_cmp
        // Data only matters when both sides present a valid word
        assign w_diff[g] = (dut_valid[g] != dut_valid[0]) |
                           (dut_valid[g] & dut_valid[0] &
                            (dut_data[g*DATA_W +: DATA_W] != dut_data[0 +: DATA_W]));
      end
    end
  endgenerate

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_to   = 1'b0;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_RUN;
      ST_RUN: begin
        // All-stalled wins over the timeout check in the same cycle
        if (dut_step == '0) w_next = ST_SETTLE;
        else if (r_cnt == TO_LAST) begin
          w_next = ST_DONE;
          w_to   = 1'b1;
        end
      end
      ST_SETTLE: w_next = ST_CHECK;
      ST_CHECK:  w_next = ST_DONE;
      ST_DONE:   if (start) w_next = ST_RUN;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n || w_start_ok) r_cnt <= '0;
    else if (w_run && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n || w_start_ok) begin
      r_done    <= 1'b0;
      r_match   <= 1'b0;
      r_timeout <= 1'b0;
      r_mask    <= '0;
    end else if (w_to) begin
      r_done    <= 1'b1;
      r_match   <= 1'b0;
      r_timeout <= 1'b1;
      r_mask    <= '0;
    end else if (r_state == ST_CHECK) begin
      r_done    <= 1'b1;
      r_match   <= ~|w_diff;
      r_mask    <= w_diff;
    end
  end

  assign phase         = r_state;
  assign cycle_cnt     = r_cnt;
  assign done          = r_done;
  assign match         = r_match;
  assign timeout       = r_timeout;
  assign mismatch_mask = r_mask;

endmodule
